// File: rtl/calc_pkg.sv
// Shared widths, FSM encoding and port indices for the calculator's
// multiplier-sharing logic.
package calc_pkg;

  localparam int OP_W  = 9;
  localparam int RES_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick: on a tie the port that was not served last wins.
module rr_arb2
  import calc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_served == PORT1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sequencer sharing one combinational sign-magnitude multiplier
// between two requesters: capture operands, settle, register product, pulse done.
module mul_share_arb
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [OP_W-1:0]  a0,
  input  logic [OP_W-1:0]  b0,
  input  logic [OP_W-1:0]  a1,
  input  logic [OP_W-1:0]  b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [RES_W-1:0] result,
  output logic             busy,
  output logic [OP_W-1:0]  mul_a,
  output logic [OP_W-1:0]  mul_b,
  input  logic [RES_W-1:0] mul_result
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [OP_W-1:0]  opa_q, opa_d;
  logic [OP_W-1:0]  opb_q, opb_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [1:0]       pick;

  rr_arb2 u_arb (
    .req         ({req1, req0}),
    .last_served (last_q),
    .grant       (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= PORT1;
      gnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (|pick) begin
          gnt_d   = pick;
          opa_d   = pick[1] ? a1 : a0;
          opb_d   = pick[1] ? b1 : b0;
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          res_d   = mul_result;
          last_d  = gnt_q[1] ? PORT1 : PORT0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers, so they stay glitch-free.
  assign gnt0   = gnt_q[0];
  assign gnt1   = gnt_q[1];
  assign done0  = (state_q == ST_DONE) && gnt_q[0];
  assign done1  = (state_q == ST_DONE) && gnt_q[1];
  assign busy   = (state_q != ST_IDLE);
  assign result = res_q;
  assign mul_a  = opa_q;
  assign mul_b  = opb_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a behavioural sign-magnitude multiplier.
module tb_mul_share_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [8:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [17:0] result;
  logic [8:0]  mul_a, mul_b;
  logic [17:0] mul_result;
  logic [15:0] prod_mag;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  assign prod_mag   = {8'd0, mul_a[7:0]} * {8'd0, mul_b[7:0]};
  assign mul_result = {mul_a[8] ^ mul_b[8], 1'b0, prod_mag};

  mul_share_arb #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .a0         (a0),
    .b0         (b0),
    .a1         (a1),
    .b1         (b1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .done0      (done0),
    .done1      (done1),
    .result     (result),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts negedge samples until the requested port's done is seen (bounded).
  task automatic wait_done(input int port, output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if ((port == 0 && done0) || (port == 1 && done1)) break;
    end
    $display("[TB] port%0d done after %0d cycles result=%h", port, cycles, result);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {gnt0, gnt1, done0, done1, busy}, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single request: 3 * 5, operand change after grant must not matter
    @(negedge clk);
    req0 = 1'b1; a0 = 9'h003; b0 = 9'h005;
    @(posedge clk); @(negedge clk);
    chk("single_gnt", {gnt0, gnt1, busy, done0}, 4'b1010);
    chk("single_mul_a", mul_a, 9'h003);
    chk("single_mul_b", mul_b, 9'h005);
    a0 = 9'h0FF;
    wait_done(0, n);
    chk("single_latency", n, 2);
    chk("single_result", result, 18'h0000F);
    chk("single_gnt_in_done", gnt0, 1);
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("single_idle", {gnt0, done0, busy}, 3'b000);
    chk("single_mul_hold", mul_a, 9'h003);

    // Asynchronous reset mid-run, then tie out of reset
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 9'h103; b0 = 9'h004;
    req1 = 1'b1; a1 = 9'h107; b1 = 9'h106;
    @(posedge clk); @(negedge clk);
    chk("tie_first_gnt", {gnt1, gnt0}, 2'b01);
    wait_done(0, n);
    chk("tie_p0_latency", n, 2);
    chk("tie_p0_result", result, 18'h2000C);
    chk("tie_p0_no_done1", done1, 0);
    req0 = 1'b0;
    wait_done(1, n);
    chk("tie_p1_back2back", n, 4);
    chk("tie_p1_result", result, 18'h0002A);
    req1 = 1'b0;
    @(posedge clk); @(negedge clk);

    // Second tie: port 0 wins again; edge-value products
    req0 = 1'b1; a0 = 9'h100; b0 = 9'h005;
    req1 = 1'b1; a1 = 9'h0FF; b1 = 9'h1FF;
    @(posedge clk); @(negedge clk);
    chk("tie2_gnt", {gnt1, gnt0}, 2'b01);
    wait_done(0, n);
    chk("negzero_result", result, 18'h20000);
    req0 = 1'b0;
    wait_done(1, n);
    chk("tie2_p1_latency", n, 4);
    chk("maxmag_result", result, 18'h2FE01);
    req1 = 1'b0;
    @(posedge clk); @(negedge clk);

    // Reset during SETTLE with req1 held
    req1 = 1'b1; a1 = 9'h005; b1 = 9'h007;
    @(posedge clk); @(negedge clk);
    chk("abort_gnt", {gnt1, busy}, 2'b11);
    rst_n = 1'b0;
    #1 chk("abort_outs", {gnt0, gnt1, done0, done1, busy}, 0);
    chk("abort_result", result, 0);
    @(posedge clk); @(negedge clk);
    chk("abort_no_done", {done0, done1}, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_regrant", {gnt1, gnt0, busy}, 3'b101);
    wait_done(1, n);
    chk("abort_latency", n, 2);
    chk("abort_result2", result, 18'h00023);
    req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("final_idle", {gnt1, done1, busy}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
